// File: rtl/sh_conv_pkg.sv
// -----------------------------------------------------------------------------
// sh_conv_pkg
// Shared definitions for the sample-and-hold conversion controller:
//   - conv_state_t : controller FSM state encoding
//   - *_DEF        : default parameter constants
//   - CNT_W        : width of the phase timing counter
//   - is_undriven  : detects an undriven/unknown analog level. In this
//                    real-valued model wrealZState/wrealXState are carried
//                    as NaN, so a value that does not compare equal to
//                    itself is treated as undriven.
// -----------------------------------------------------------------------------
package sh_conv_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SAMPLE      = 3'd1,
    GAP         = 3'd2,
    HOLD_SETTLE = 3'd3,
    CONVERT     = 3'd4,
    DONE        = 3'd5
  } conv_state_t;

  localparam int  NBITS_DEF      = 10;
  localparam int  SAMP_CYC_DEF   = 4;
  localparam int  GAP_CYC_DEF    = 1;
  localparam int  SETTLE_CYC_DEF = 8;
  localparam real VREF_DEF       = 2.0;

  // Phase counter width; all phase lengths must stay below 2**CNT_W.
  localparam int  CNT_W          = 8;

  function automatic logic is_undriven(input real v);
    return (v != v) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sh_conv_ctrl_if.sv
// -----------------------------------------------------------------------------
// sh_conv_ctrl_if
// Bundles the control, analog and result signals of sh_conv_ctrl.
//   master : requester side (drives en_req, start, outp, outm, code_ready)
//   slave  : controller side (drives en, samp, hold, code, code_valid,
//            busy, err)
// -----------------------------------------------------------------------------
interface sh_conv_ctrl_if #(
  parameter int NBITS = 10
);
  logic             en_req;
  logic             start;
  real              outp;
  real              outm;
  logic             en;
  logic             samp;
  logic             hold;
  logic [NBITS-1:0] code;
  logic             code_valid;
  logic             code_ready;
  logic             busy;
  logic             err;

  modport master (
    output en_req, start, outp, outm, code_ready,
    input  en, samp, hold, code, code_valid, busy, err
  );

  modport slave (
    input  en_req, start, outp, outm, code_ready,
    output en, samp, hold, code, code_valid, busy, err
  );
endinterface

// File: rtl/sh_sar_cmp.sv
// -----------------------------------------------------------------------------
// sh_sar_cmp
// Combinational SAR threshold compare.
//   diff  : differential held input (outp - outm), volts
//   trial : current SAR result with the bit under test set
//   keep  : 1 when diff >= -VREF + trial * 2*VREF / 2**NBITS
// -----------------------------------------------------------------------------
module sh_sar_cmp #(
  parameter int  NBITS = 10,
  parameter real VREF  = 2.0
) (
  input  real              diff,
  input  logic [NBITS-1:0] trial,
  output logic             keep
);

  // One code step in volts; a power-of-two division keeps it exact.
  localparam real STEP = (2.0 * VREF) / real'(32'd1 << NBITS);

  real thresh;

  // Threshold for the trial code and the keep decision.
  always_comb begin
    thresh = -VREF + real'(trial) * STEP;
    keep   = (diff >= thresh) ? 1'b1 : 1'b0;
  end

endmodule

// File: rtl/sh_conv_ctrl.sv
// -----------------------------------------------------------------------------
// sh_conv_ctrl
// Sample-and-hold sequencing plus SAR conversion of the held differential.
// Ports:
//   clk   : single clock
//   rst_n : asynchronous active-low reset
//   bus   : sh_conv_ctrl_if.slave (en_req, start, outp, outm, code_ready in;
//           en, samp, hold, code, code_valid, busy, err out)
// Timeline after the start-accept edge (edge 0): samp high for edges
// 1..SAMP_CYC, GAP_CYC low cycles, hold through SETTLE_CYC settle clocks
// and NBITS bit decisions, then code/code_valid on the edge hold falls.
// Optional feature: define SH_CONV_ZCHK_EN to flag undriven/X analog inputs
// during CONVERT (sets sticky err and aborts). Without it err is tied low.
// -----------------------------------------------------------------------------
module sh_conv_ctrl
  import sh_conv_pkg::*;
#(
  parameter int  NBITS      = NBITS_DEF,
  parameter int  SAMP_CYC   = SAMP_CYC_DEF,
  parameter int  GAP_CYC    = GAP_CYC_DEF,
  parameter int  SETTLE_CYC = SETTLE_CYC_DEF,
  parameter real VREF       = VREF_DEF
) (
  input logic           clk,
  input logic           rst_n,
  sh_conv_ctrl_if.slave bus
);

  conv_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [NBITS-1:0] result_r;
  logic [NBITS-1:0] mask_r;       // one-hot bit under test, MSB first
  logic [NBITS-1:0] code_r;
  logic             en_r;
  logic             samp_r;
  logic             hold_r;
  logic             code_valid_r;
  logic             busy_r;

  real              diff_s;
  logic [NBITS-1:0] trial_s;
  logic [NBITS-1:0] next_result_s;
  logic             keep_s;

  // Differential input and next SAR result for the bit under test.
  always_comb begin
    diff_s        = bus.outp - bus.outm;
    trial_s       = result_r | mask_r;
    next_result_s = keep_s ? trial_s : result_r;
  end

  sh_sar_cmp #(
    .NBITS (NBITS),
    .VREF  (VREF)
  ) u_cmp (
    .diff  (diff_s),
    .trial (trial_s),
    .keep  (keep_s)
  );

`ifdef SH_CONV_ZCHK_EN
  logic err_r;
  logic bad_in_s;

  // Either held output undriven or unknown.
  always_comb begin
    bad_in_s = is_undriven(bus.outp) | is_undriven(bus.outm);
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  // Controller FSM with registered phase and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      result_r     <= {NBITS{1'b0}};
      mask_r       <= {NBITS{1'b0}};
      code_r       <= {NBITS{1'b0}};
      en_r         <= 1'b0;
      samp_r       <= 1'b0;
      hold_r       <= 1'b0;
      code_valid_r <= 1'b0;
      busy_r       <= 1'b0;
`ifdef SH_CONV_ZCHK_EN
      err_r        <= 1'b0;
`endif
    end else begin
      en_r <= bus.en_req;
      if ((state_r != IDLE) && !bus.en_req) begin
        // Enable withdrawn: abandon the conversion, keep the last code.
        state_r      <= IDLE;
        cnt_r        <= {CNT_W{1'b0}};
        samp_r       <= 1'b0;
        hold_r       <= 1'b0;
        code_valid_r <= 1'b0;
        busy_r       <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (bus.start && en_r) begin
              state_r <= SAMPLE;
              cnt_r   <= {CNT_W{1'b0}};
              busy_r  <= 1'b1;
`ifdef SH_CONV_ZCHK_EN
              err_r   <= 1'b0;
`endif
            end else begin
              state_r <= IDLE;
            end
          end
          SAMPLE: begin
            // The accept edge is the first SAMPLE cycle, so samp stays
            // high for exactly SAMP_CYC clocks after it.
            if (cnt_r == CNT_W'(SAMP_CYC)) begin
              state_r <= GAP;
              samp_r  <= 1'b0;
              cnt_r   <= {CNT_W{1'b0}};
            end else begin
              samp_r  <= 1'b1;
              cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
          GAP: begin
            if (cnt_r == CNT_W'(GAP_CYC - 1)) begin
              state_r <= HOLD_SETTLE;
              hold_r  <= 1'b1;
              cnt_r   <= {CNT_W{1'b0}};
            end else begin
              cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
          HOLD_SETTLE: begin
            if (cnt_r == CNT_W'(SETTLE_CYC - 1)) begin
              state_r  <= CONVERT;
              cnt_r    <= {CNT_W{1'b0}};
              result_r <= {NBITS{1'b0}};
              mask_r   <= {1'b1, {(NBITS-1){1'b0}}};
            end else begin
              cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
          CONVERT: begin
`ifdef SH_CONV_ZCHK_EN
            if (bad_in_s) begin
              err_r        <= 1'b1;
              state_r      <= IDLE;
              hold_r       <= 1'b0;
              code_valid_r <= 1'b0;
              busy_r       <= 1'b0;
            end else
`endif
            if (mask_r[0]) begin
              // Last bit: publish the result on the edge hold falls.
              state_r      <= DONE;
              result_r     <= next_result_s;
              mask_r       <= {NBITS{1'b0}};
              hold_r       <= 1'b0;
              code_r       <= next_result_s;
              code_valid_r <= 1'b1;
            end else begin
              result_r     <= next_result_s;
              mask_r       <= mask_r >> 1;
            end
          end
          DONE: begin
            if (bus.code_ready) begin
              state_r      <= IDLE;
              code_valid_r <= 1'b0;
              busy_r       <= 1'b0;
            end else begin
              state_r      <= DONE;
            end
          end
          default: begin
            state_r      <= IDLE;
            samp_r       <= 1'b0;
            hold_r       <= 1'b0;
            code_valid_r <= 1'b0;
            busy_r       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.en         = en_r;
  assign bus.samp       = samp_r;
  assign bus.hold       = hold_r;
  assign bus.code       = code_r;
  assign bus.code_valid = code_valid_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_sh_conv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sh_conv_ctrl
// Self-checking bench for sh_conv_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// timeline model (cycles since the accept edge) and an ideal quantizer.
// -----------------------------------------------------------------------------
module tb_sh_conv_ctrl;

  localparam int  NB  = 10;
  localparam int  SC  = 4;
  localparam int  GC  = 1;
  localparam int  STC = 8;
  localparam real VR  = 2.0;
  localparam int  LAT = 1 + SC + GC + STC + NB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sh_conv_ctrl_if #(.NBITS(NB)) bus();

  sh_conv_ctrl #(
    .NBITS(NB), .SAMP_CYC(SC), .GAP_CYC(GC), .SETTLE_CYC(STC), .VREF(VR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Ideal quantizer: clamp(floor((diff+VREF)*2^N/(2*VREF)), 0, 2^N-1).
  function automatic int ref_code(input real d);
    real x;
    x = $floor((d + VR) * real'(1 << NB) / (2.0 * VR));
    if (x < 0.0) return 0;
    if (x > real'((1 << NB) - 1)) return (1 << NB) - 1;
    return $rtoi(x);
  endfunction

  // ---------------- behavioural model ----------------
  bit m_active;
  int m_t;
  bit m_valid;
  int m_code;
  bit m_en;
  bit model_on = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_t = 0; m_valid = 0; m_code = 0; m_en = 0;
    end else begin
      if (m_active) begin
        if (!bus.en_req) begin
          m_active = 0; m_valid = 0;
        end else if (m_valid) begin
          if (bus.code_ready) begin m_active = 0; m_valid = 0; end
        end else begin
          m_t++;
          if (m_t == LAT) begin
            m_valid = 1;
            m_code  = ref_code(bus.outp - bus.outm);
          end
        end
      end else if (bus.start && m_en) begin
        m_active = 1; m_t = 0;
      end
      m_en = bus.en_req;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && model_on) begin
      chk("en", bus.en, m_en);
      chk("samp", bus.samp, m_active && !m_valid && m_t >= 1 && m_t <= SC);
      chk("hold", bus.hold, m_active && !m_valid && m_t >= SC + GC + 1);
      chk("busy", bus.busy, m_active);
      chk("code_valid", bus.code_valid, m_valid);
      chk("code", bus.code, m_code);
      chk("err", bus.err, 1'b0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_diff(input real d);
    bus.outm = 0.25;
    bus.outp = d + 0.25;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_conv(input real d, input int exp_code, input string name, input bit release_it);
    longint samp_mask, hold_mask;
    int lat;
    set_diff(d);
    @(negedge clk);
    pulse_start();
    samp_mask = 0; hold_mask = 0; lat = 0;
    for (int n = 1; n <= 60 && lat == 0; n++) begin
      @(negedge clk);
      if (bus.samp) samp_mask |= (64'd1 << n);
      if (bus.hold) hold_mask |= (64'd1 << n);
      if (bus.code_valid) lat = n;
    end
    chk({name, "_latency"}, lat, 24);
    chk({name, "_code"}, bus.code, exp_code);
    chk({name, "_samp_cycles"}, samp_mask[31:0], 32'h0000_001E);
    chk({name, "_hold_cycles"}, hold_mask[31:0], 32'h00FF_FFC0);
    if (release_it) begin
      bus.code_ready = 1'b1;
      @(negedge clk);
      bus.code_ready = 1'b0;
      chk({name, "_idle_after_ready"}, bus.busy, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.en_req = 1'b0; bus.start = 1'b0; bus.code_ready = 1'b0;
    bus.outp = 0.0; bus.outm = 0.0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_en", bus.en, 1'b0);
    chk("rst_samp", bus.samp, 1'b0);
    chk("rst_hold", bus.hold, 1'b0);
    chk("rst_code", bus.code, 0);
    chk("rst_code_valid", bus.code_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    rst_n = 1'b1;
    bus.en_req = 1'b1;
    @(negedge clk);

    // Basic conversions including clamps
    run_conv(0.0, 512, "zero", 1'b1);
    run_conv(1.0, 768, "plus1", 1'b1);
    run_conv(-1.0, 256, "minus1", 1'b1);
    run_conv(2.5, 1023, "clamp_hi", 1'b1);
    run_conv(-2.5, 0, "clamp_lo", 1'b1);

    // Consumer stalls 10 cycles with a stray start in the window
    run_conv(-1.0, 256, "stall", 1'b0);
    for (int i = 1; i <= 10; i++) begin
      bus.start = (i == 3);
      @(negedge clk);
      chk("stall_code_stable", bus.code, 256);
      chk("stall_no_samp", bus.samp, 1'b0);
    end
    bus.start = 1'b0;
    bus.code_ready = 1'b1;
    @(negedge clk);
    bus.code_ready = 1'b0;
    chk("stall_ready_busy", bus.busy, 1'b0);
    chk("stall_ready_valid", bus.code_valid, 1'b0);
    repeat (3) @(negedge clk);
    chk("stall_start_not_queued", bus.busy, 1'b0);

    // Enable withdrawn during hold settle
    set_diff(1.0);
    @(negedge clk);
    pulse_start();
    repeat (8) @(negedge clk);
    bus.en_req = 1'b0;
    @(negedge clk);
    chk("endrop_hold", bus.hold, 1'b0);
    chk("endrop_busy", bus.busy, 1'b0);
    bus.en_req = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.code_valid) seen = 1;
    end
    chk("endrop_no_valid", seen, 1'b0);
    chk("endrop_code_kept", bus.code, 256);

    // Reset during CONVERT
    set_diff(1.0);
    @(negedge clk);
    pulse_start();
    repeat (16) @(negedge clk);
    chk("rstconv_in_hold", bus.hold, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstconv_samp", bus.samp, 1'b0);
    chk("rstconv_hold", bus.hold, 1'b0);
    chk("rstconv_busy", bus.busy, 1'b0);
    chk("rstconv_code", bus.code, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_conv(0.75, 704, "after_rst", 1'b1);

    // Randomized traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (!m_active && $urandom_range(0, 3) == 0) begin
        int r;
        real d;
        r = int'($urandom_range(0, 1279)) - 128;
        d = -2.0 + (real'(r) + 0.5) / 256.0;
        bus.outm = (real'($urandom_range(0, 1024)) - 512.0) / 512.0;
        bus.outp = d + bus.outm;
      end
      bus.start      = ($urandom_range(0, 5) == 0);
      bus.code_ready = ($urandom_range(0, 2) == 0);
      bus.en_req     = ($urandom_range(0, 99) != 0);
    end
    bus.start = 1'b0;
    bus.en_req = 1'b1;
    bus.code_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.code_ready = 1'b0;

`ifdef SH_CONV_ZCHK_EN
    // Undriven input during CONVERT
    run_conv(1.0, 768, "zchk_pre", 1'b1);
    model_on = 1'b0;
    @(negedge clk);
    pulse_start();
    repeat (16) @(negedge clk);
    bus.outp = $bitstoreal(64'h7FF8_0000_0000_0000);
    @(negedge clk);
    chk("zchk_err", bus.err, 1'b1);
    chk("zchk_valid", bus.code_valid, 1'b0);
    chk("zchk_code_kept", bus.code, 768);
    repeat (30) @(negedge clk);
    chk("zchk_valid_late", bus.code_valid, 1'b0);
    chk("zchk_err_sticky", bus.err, 1'b1);
    set_diff(1.0);
    pulse_start();
    chk("zchk_err_cleared", bus.err, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
